// File: rtl/uart_wb_bridge_pkg.sv
// uart_wb_bridge shared definitions: frame/response codes and FSM states.
// Optional bus timeout is enabled with `define UART_WB_TIMEOUT_EN.
package uart_wb_bridge_pkg;

   localparam logic [7:0] CMD_WR  = 8'h01;
   localparam logic [7:0] CMD_RD  = 8'h02;
   localparam logic [7:0] RSP_OK  = 8'hAA;
   localparam logic [7:0] RSP_ERR = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } state_t;

   function automatic logic [31:0] shl8(
      input logic [31:0] w,
      input logic [7:0]  b
   );
      return {w[23:0], b};
   endfunction

endpackage

// File: rtl/uart_wb_bridge_if.sv
// UART byte handshake plus Wishbone master signals of the bridge.
// master = bridge side, slave = UART core and system bus side.
interface uart_wb_bridge_if;

   logic [7:0]  rx_data;
   logic        rx_avail;
   logic        rx_error;
   logic        rx_ack;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_busy;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   modport master (
      input  rx_data, rx_avail, rx_error, tx_busy,
      input  wb_dat_i, wb_ack_i,
      output rx_ack, tx_data, tx_wr,
      output wb_cyc_o, wb_stb_o, wb_we_o,
      output wb_adr_o, wb_dat_o, wb_sel_o
   );

   modport slave (
      output rx_data, rx_avail, rx_error, tx_busy,
      output wb_dat_i, wb_ack_i,
      input  rx_ack, tx_data, tx_wr,
      input  wb_cyc_o, wb_stb_o, wb_we_o,
      input  wb_adr_o, wb_dat_o, wb_sel_o
   );

endinterface

// File: rtl/uart_wb_bridge_resp.sv
// uart_wb_resp: serializes a left-aligned word (1 or 4 bytes) MSB first
// to the UART transmitter; o_done is high during the final tx_wr cycle.
module uart_wb_resp (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_load,
   input  logic [31:0] i_word,
   input  logic        i_four,
   input  logic        i_tx_busy,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_wr,
   output logic        o_done
);

   logic [31:0] r_word;
   logic [2:0]  r_left;
   logic        r_hold;
   logic [7:0]  r_tx_data;
   logic        r_tx_wr;
   logic        w_send;

   // busy is not trusted in the strobe cycle nor in the one after it
   assign w_send = (r_left != 3'd0) && !r_tx_wr && !r_hold && !i_tx_busy;

   // load the word, then emit one byte per free transmitter slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_word    <= '0;
         r_left    <= '0;
         r_hold    <= 1'b0;
         r_tx_data <= '0;
         r_tx_wr   <= 1'b0;
      end else begin
         r_hold  <= r_tx_wr;
         r_tx_wr <= 1'b0;
         if (i_load) begin
            r_word <= i_word;
            r_left <= i_four ? 3'd4 : 3'd1;
         end else if (w_send) begin
            r_tx_data <= r_word[31:24];
            r_word    <= {r_word[23:0], 8'h00};
            r_left    <= r_left - 3'd1;
            r_tx_wr   <= 1'b1;
         end
      end
   end

   assign o_tx_data = r_tx_data;
   assign o_tx_wr   = r_tx_wr;
   assign o_done    = r_tx_wr && (r_left == 3'd0);

endmodule

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART command frames to single 32-bit Wishbone cycles.
// Define UART_WB_TIMEOUT_EN to abort unacked cycles after timeout_cycles.
module uart_wb_bridge
   import uart_wb_bridge_pkg::*;
`ifdef UART_WB_TIMEOUT_EN
#(
   parameter int timeout_cycles = 1024
)
`endif
(
   input logic               clk,
   input logic               reset_n,
   uart_wb_bridge_if.master  bus
);

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic        r_wr;
   logic        r_rx_ack;
   logic        r_cyc;
   logic        r_we;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;

   logic        w_take;
   logic        w_tmo;
   logic        w_load;
   logic        w_four;
   logic [31:0] w_word;
   logic        w_done;
   logic [7:0]  w_tx_data;
   logic        w_tx_wr;

   assign w_take = bus.rx_avail && !r_rx_ack;

`ifdef UART_WB_TIMEOUT_EN
   localparam int TW = $clog2(timeout_cycles + 1);
   logic [TW-1:0] r_tcnt;

   assign w_tmo = (r_tcnt + TW'(1)) == TW'(timeout_cycles);

   // count unacked cycles spent in BUS
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_tcnt <= '0;
      else if (r_state == ST_BUS && !bus.wb_ack_i && !w_tmo)
         r_tcnt <= r_tcnt + TW'(1);
      else
         r_tcnt <= '0;
   end
`else
   assign w_tmo = 1'b0;
`endif

   // ack wins over a coincident timeout
   assign w_load = (r_state == ST_BUS) && (bus.wb_ack_i || w_tmo);
   assign w_four = bus.wb_ack_i && !r_wr;
   assign w_word = !bus.wb_ack_i ? {RSP_ERR, 24'h0} :
                   r_wr          ? {RSP_OK, 24'h0}  :
                                   bus.wb_dat_i;

   // frame parser, bus cycle control and response sequencing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_wr     <= 1'b0;
         r_rx_ack <= 1'b0;
         r_cyc    <= 1'b0;
         r_we     <= 1'b0;
         r_adr    <= '0;
         r_dat    <= '0;
         r_sel    <= '0;
      end else begin
         r_rx_ack <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_rx_ack <= 1'b1;
                  r_cnt    <= '0;
                  if (bus.rx_data == CMD_WR) begin
                     r_wr    <= 1'b1;
                     r_state <= ST_ADDR;
                  end else if (bus.rx_data == CMD_RD) begin
                     r_wr    <= 1'b0;
                     r_state <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (bus.rx_error) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else if (w_take) begin
                  r_rx_ack <= 1'b1;
                  r_adr    <= shl8(r_adr, bus.rx_data);
                  r_cnt    <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     if (r_wr) begin
                        r_state <= ST_DATA;
                     end else begin
                        r_state <= ST_BUS;
                        r_cyc   <= 1'b1;
                        r_we    <= 1'b0;
                        r_sel   <= 4'hF;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (bus.rx_error) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else if (w_take) begin
                  r_rx_ack <= 1'b1;
                  r_dat    <= shl8(r_dat, bus.rx_data);
                  r_cnt    <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_state <= ST_BUS;
                     r_cyc   <= 1'b1;
                     r_we    <= 1'b1;
                     r_sel   <= 4'hF;
                  end
               end
            end
            ST_BUS: begin
               if (w_load) begin
                  r_cyc   <= 1'b0;
                  r_we    <= 1'b0;
                  r_sel   <= '0;
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (w_done)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   uart_wb_resp u_resp (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_load),
      .i_word    (w_word),
      .i_four    (w_four),
      .i_tx_busy (bus.tx_busy),
      .o_tx_data (w_tx_data),
      .o_tx_wr   (w_tx_wr),
      .o_done    (w_done)
   );

   assign bus.rx_ack   = r_rx_ack;
   assign bus.tx_data  = w_tx_data;
   assign bus.tx_wr    = w_tx_wr;
   assign bus.wb_cyc_o = r_cyc;
   assign bus.wb_stb_o = r_cyc;
   assign bus.wb_we_o  = r_we;
   assign bus.wb_adr_o = r_adr;
   assign bus.wb_dat_o = r_dat;
   assign bus.wb_sel_o = r_sel;

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

UART-to-Wishbone master bridge: parses command frames arriving byte-wise from the system UART (host side, e.g. the bench UART partner), executes single 32-bit Wishbone read/write cycles, and returns response bytes through the same UART. It sits between the `uart` core's rx/tx byte handshake and a Wishbone master port on the system bus, giving the host debug access to memory and peripherals next to the LM32.

## Interface
- `timeout_cycles`, 1024: bus cycles to wait for `wb_ack_i` before aborting (only with `UART_WB_TIMEOUT_EN`).
- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte from the `uart` core.
- `rx_avail` in 1: level; byte valid until acknowledged.
- `rx_error` in 1: framing error pulse from the `uart` core.
- `rx_ack` out 1: one-cycle pulse that consumes `rx_data`.
- `tx_data` out 8: response byte.
- `tx_wr` out 1: one-cycle write strobe.
- `tx_busy` in 1: UART transmitter busy.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone master controls.
- `wb_adr_o` out 32: byte address.
- `wb_dat_o` out 32: write data.
- `wb_sel_o` out 4: byte selects, always 4'hF during a cycle.
- `wb_dat_i` in 32: read data.
- `wb_ack_i` in 1: slave acknowledge.

## Operation
- Frame layout: command byte, then 4 address bytes MSB first, then (write only) 4 data bytes MSB first.
  - `CMD_WR` = 0x01.
  - `CMD_RD` = 0x02.
  - Any other command byte is consumed and dropped; the FSM stays in IDLE.
- FSM states:
  - IDLE: waits for a command byte. Valid command goes to ADDR.
  - ADDR: collects 4 address bytes, then goes to DATA (write) or BUS (read).
  - DATA: collects 4 data bytes, then goes to BUS.
  - BUS: runs the Wishbone cycle. Goes to RESP on `wb_ack_i`, or on timeout.
  - RESP: sends the response bytes, then returns to IDLE.
- Responses:
  - Write acked: one byte `RSP_OK` = 0xAA.
  - Read acked: 4 bytes of the read data, MSB first.
  - Timeout: one byte `RSP_ERR` = 0xEE.
- Rx consume rule: consume only when `rx_avail && !rx_ack`. Assert `rx_ack` for exactly one cycle per byte; no byte is consumed twice.
- Bytes are consumed only in IDLE, ADDR and DATA. During BUS and RESP, `rx_ack` stays 0 and the byte stays pending in the UART.
- `rx_error` in ADDR or DATA: discard the partial frame, go to IDLE, no bus cycle, no response. `rx_error` in IDLE, BUS or RESP is ignored.
- Byte counter is 2 bits and wraps 3→0 on the last byte of each field.
- Address and data are assembled by left-shifting 8 bits per byte.

## Timing
- Reset values: every output is 0 (`rx_ack`, `tx_wr`, `tx_data`, all `wb_*`). FSM = IDLE, counter = 0.
- `reset_n` low mid-frame or mid-cycle drops `wb_cyc_o`/`wb_stb_o` immediately (asynchronously). No response is sent.
- Bus cycle start: `wb_cyc_o`/`wb_stb_o` rise the cycle after the final frame byte is consumed. `wb_adr_o`, `wb_we_o`, `wb_dat_o` and `wb_sel_o` are stable for the whole cycle.
- Bus cycle end: `wb_ack_i` is sampled at the clock edge. On that edge `cyc`/`stb` deassert and `wb_dat_i` is latched. Single-cycle acks are supported.
- Tx handshake:
  - The first `tx_wr` comes no earlier than the cycle after the ack (or timeout).
  - Issue `tx_wr` only when `tx_busy` = 0.
  - After each `tx_wr`, ignore `tx_busy` for one cycle, then wait for `tx_busy` = 0 before the next byte.
- RESP → IDLE happens on the cycle after the final `tx_wr`. `tx_busy` is not awaited for the last byte.

## Configuration
- `UART_WB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(timeout_cycles+1)` runs in BUS.
  - When it reaches `timeout_cycles` without an ack, `cyc`/`stb` drop and `RSP_ERR` is sent.
  - A simultaneous ack and timeout resolves as an ack.
- Not defined: no counter; BUS waits indefinitely for `wb_ack_i`. `RSP_ERR` is never generated.

## Structure
- `uart_wb_include.v` (`define`s, same style as `ddr_include.v`) holds:
  - `CMD_WR`, `CMD_RD`, `RSP_OK`, `RSP_ERR`.
  - The state encodings.
- Sub-module `uart_wb_resp`:
  - Loads a 32-bit word plus a byte count (1 or 4).
  - Serializes the bytes MSB first under the tx handshake.
  - Reports `done`.
- The parser, FSM and Wishbone logic stay in `uart_wb_bridge`.

## Test plan
- Write frame 01 00 00 10 00 DE AD BE EF:
  - One Wishbone cycle with `adr`=0x00001000, `we`=1, `dat_o`=0xDEADBEEF, `sel`=F.
  - Tx sends 0xAA.
- Read frame 02 00 00 10 00, slave acks with 0x12345678 after 3 wait cycles:
  - Tx sends 12 34 56 78 in that order.
- Unknown command 0x7F, then a valid read frame:
  - 0x7F is consumed with no bus cycle and no tx.
  - The read completes normally.
- `rx_error` pulse after 2 address bytes, then a full write frame:
  - Only the second frame produces a bus cycle and 0xAA.
- With `UART_WB_TIMEOUT_EN` and `timeout_cycles`=16, slave never acks:
  - `cyc` drops after 16 cycles and 0xEE is sent.
  - Same case with ack and timeout on the same cycle gives 0xAA.
- `reset_n` low during BUS:
  - `cyc`/`stb` drop immediately, no tx follows.
  - The next frame after release is processed correctly.
